// File: rtl/poliriscv_imem_loader_if.sv
// Byte-stream handshake feeding the instruction-memory loader.
//   valid : source has a byte on data
//   data  : stream byte
//   ready : loader accepts the byte this cycle
// master = stream source, slave = loader.
interface poliriscv_imem_loader_if;
  localparam int unsigned BYTE_W = 8;

  logic              valid;
  logic [BYTE_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/poliriscv_imem_loader.sv
// Boot-time program loader. Consumes a byte stream (16-bit little-endian word
// count, then little-endian 32-bit instructions), writes each assembled word to
// the instruction-memory write port and holds the core in reset until the whole
// image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// checksum byte after the data (8-bit sum of data bytes plus it must be 0).
// Ports:
//   clk_i           clock
//   rst_n_i         asynchronous active-low reset
//   start_i         one-cycle pulse, begins a load from IDLE/DONE/ERR
//   s_if            byte stream (slave side)
//   im_we_o         instruction-memory write strobe, one cycle per word
//   im_addr_o       word address of the write
//   im_wdata_o      instruction word
//   cpu_rst_o       active-high reset to the core
//   busy_o          load in progress
//   done_o          image loaded, core released
//   err_o           load aborted
//   words_loaded_o  words written in the current load
module poliriscv_imem_loader #(
  parameter int unsigned INSTR_WORDS = 256,
  parameter int unsigned AW          = $clog2(INSTR_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  poliriscv_imem_loader_if.slave s_if,
  output logic                   im_we_o,
  output logic [AW-1:0]          im_addr_o,
  output logic [31:0]            im_wdata_o,
  output logic                   cpu_rst_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [15:0]            words_loaded_o
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BUF_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         bidx_q, bidx_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               accept;
  logic [LEN_W-1:0]   hdr_len;
  logic               last_word;

  assign accept    = s_if.valid && ready_q;
  assign hdr_len   = {s_if.data, len_q[7:0]};
  assign last_word = (LEN_W'(cnt_q + 16'd1) == len_q);

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN0;
          len_d   = '0;
          cnt_d   = '0;
          bidx_d  = '0;
          buf_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = s_if.data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = hdr_len;
          if (hdr_len == '0)                    state_d = DONE;
          else if (32'(hdr_len) > INSTR_WORDS)  state_d = ERR;
          else                                  state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = 8'(sum_q + s_if.data);
`endif
          bidx_d = 2'(bidx_q + 2'd1);
          case (bidx_q)
            2'd0: buf_d[7:0]   = s_if.data;
            2'd1: buf_d[15:8]  = s_if.data;
            2'd2: buf_d[23:16] = s_if.data;
            default: begin
              // Fourth byte completes the word: strobe it out next cycle.
              we_d    = 1'b1;
              addr_d  = cnt_q[AW-1:0];
              wdata_d = {s_if.data, buf_q};
              cnt_d   = LEN_W'(cnt_q + 16'd1);
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = CHK;
`else
                state_d = DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          if (8'(sum_q + s_if.data) == 8'd0) state_d = DONE;
          else                               state_d = ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Status outputs follow the state being entered so they are registered
    // yet aligned with it (done/cpu_rst move together with the last im_we).
    ready_d   = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                || (state_d == CHK)
`endif
                ;
    busy_d    = ready_d;
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
    cpu_rst_d = (state_d != DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      bidx_q    <= '0;
      buf_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      bidx_q    <= bidx_d;
      buf_q     <= buf_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign s_if.ready     = ready_q;
  assign im_we_o        = we_q;
  assign im_addr_o      = addr_q;
  assign im_wdata_o     = wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_poliriscv_imem_loader.sv
// Directed bench for the instruction-memory loader: table of complete load
// images plus hand sequences for reset mid-load, zero length, restart, the
// maximum length and (when enabled) the checksum byte.
module tb_poliriscv_imem_loader;

  localparam int unsigned AW = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   words_loaded;

  poliriscv_imem_loader_if sif ();

  poliriscv_imem_loader #(.INSTR_WORDS(256), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .s_if           (sif),
    .im_we_o        (im_we),
    .im_addr_o      (im_addr),
    .im_wdata_o     (im_wdata),
    .cpu_rst_o      (cpu_rst),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_viol = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  bit          wr_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and handshake watch, sampled mid-cycle
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(im_wdata);
      wr_done.push_back(done);
    end
    if (sif.ready && (!busy || done)) ready_viol++;
  end

  typedef struct {
    logic [103:0] stream;
    int           n;
    bit           toggle;
    bit           e_done;
    bit           e_err;
    bit           e_cpu_rst;
    int           e_words;
    logic [31:0]  e_w0;
    logic [31:0]  e_w1;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [103:0] s, input int n, input bit tg,
                              input bit d, input bit e, input bit cr,
                              input int w, input logic [31:0] w0,
                              input logic [31:0] w1);
    vec_t v;
    v.stream = s; v.n = n; v.toggle = tg;
    v.e_done = d; v.e_err = e; v.e_cpu_rst = cr;
    v.e_words = w; v.e_w0 = w0; v.e_w1 = w1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and return on the negedge after it was accepted.
  task automatic send(input logic [7:0] b, input bit toggle);
    int n = 0;
    if (toggle) begin
      sif.valid = 1'b0;
      @(negedge clk);
    end
    sif.valid = 1'b1;
    sif.data  = b;
    while (!sif.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("send_timeout", 32'd1, 32'd0);
      sif.valid = 1'b0;
      return;
    end
    @(negedge clk);
    sif.valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
  endtask

  initial begin
    int t0;
    int mism;
    vec_t v;

    rst_n = 1'b0;
    start = 1'b0;
    sif.valid = 1'b0;
    sif.data  = 8'h00;

    // Image table: streams are stored first byte in [7:0]
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[0] = mk(104'hF2DDCCBBAA0001, 7, 1'b0, 1, 0, 0, 1, 32'hDDCCBBAA, 32'h0);
    vecs[1] = mk(104'h2000200593001005130002, 11, 1'b0, 1, 0, 0, 2, 32'h00100513, 32'h00200593);
    vecs[2] = mk(104'h2000200593001005130002, 11, 1'b1, 1, 0, 0, 2, 32'h00100513, 32'h00200593);
    vecs[5] = mk(104'hC8DEADBEEF0001, 7, 1'b1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0);
`else
    vecs[0] = mk(104'hDDCCBBAA0001, 6, 1'b0, 1, 0, 0, 1, 32'hDDCCBBAA, 32'h0);
    vecs[1] = mk(104'h00200593001005130002, 10, 1'b0, 1, 0, 0, 2, 32'h00100513, 32'h00200593);
    vecs[2] = mk(104'h00200593001005130002, 10, 1'b1, 1, 0, 0, 2, 32'h00100513, 32'h00200593);
    vecs[5] = mk(104'hDEADBEEF0001, 6, 1'b1, 1, 0, 0, 1, 32'hDEADBEEF, 32'h0);
`endif
    vecs[3] = mk(104'h0101, 2, 1'b0, 0, 1, 1, 0, 32'h0, 32'h0);
    vecs[4] = mk(104'h0000, 2, 1'b0, 1, 0, 0, 0, 32'h0, 32'h0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_we",      32'(im_we),   32'd0);
    check("rst_ready",   32'(sif.ready), 32'd0);
    check("rst_words",   32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after six data bytes: one word written, partial word dropped
    clear_log();
    do_start();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'h93, 0); send(8'h05, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_done",    32'(done),    32'd0);
    check("mid_rst_err",     32'(err),     32'd0);
    check("mid_rst_ready",   32'(sif.ready), 32'd0);
    check("mid_rst_words",   32'(words_loaded), 32'd0);
    check("mid_rst_addr",    32'(im_addr), 32'd0);
    check("mid_rst_wdata",   im_wdata,     32'd0);
    check("mid_rst_nwr",     32'(wr_data.size()), 32'd1);
    if (wr_data.size() > 0) begin
      check("mid_rst_wr0_addr", 32'(wr_addr[0]), 32'd0);
      check("mid_rst_wr0_data", wr_data[0], 32'h00100513);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven complete loads
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clear_log();
      do_start();
      t0 = cyc;
      for (int b = 0; b < v.n; b++) send(v.stream[8*b +: 8], v.toggle);
      check($sformatf("v%0d_cycles", i), 32'(cyc - t0),
            32'(v.toggle ? 2 * v.n : v.n));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_done", i),    32'(done),    32'(v.e_done));
      check($sformatf("v%0d_err", i),     32'(err),     32'(v.e_err));
      check($sformatf("v%0d_cpu_rst", i), 32'(cpu_rst), 32'(v.e_cpu_rst));
      check($sformatf("v%0d_busy", i),    32'(busy),    32'd0);
      check($sformatf("v%0d_ready", i),   32'(sif.ready), 32'd0);
      check($sformatf("v%0d_words", i),   32'(words_loaded), 32'(v.e_words));
      check($sformatf("v%0d_nwr", i),     32'(wr_data.size()), 32'(v.e_words));
      for (int w = 0; w < v.e_words && w < wr_data.size(); w++) begin
        check($sformatf("v%0d_wr%0d_addr", i, w), 32'(wr_addr[w]), 32'(w));
        check($sformatf("v%0d_wr%0d_data", i, w), wr_data[w], (w == 0) ? v.e_w0 : v.e_w1);
      end
      if (v.e_words > 0 && wr_done.size() > 0)
        check($sformatf("v%0d_done_at_last_we", i),
              32'(wr_done[wr_done.size()-1]), 32'(!CHK_EN));
    end

    // Zero length: done right after the second header byte; restart from DONE
    clear_log();
    do_start();
    send(8'h00, 0);
    send(8'h00, 0);
    check("zero_done_2bytes", 32'(done), 32'd1);
    check("zero_cpu_rel",     32'(cpu_rst), 32'd0);
    do_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_busy",    32'(busy),    32'd1);
    check("restart_done",    32'(done),    32'd0);
    check("restart_ready",   32'(sif.ready), 32'd1);
    check("restart_words",   32'(words_loaded), 32'd0);
    send(8'h00, 0);
    send(8'h00, 0);

    // Maximum length (256 words) is accepted
    clear_log();
    do_start();
    send(8'h00, 0);
    send(8'h01, 0);
    check("max_hdr_busy", 32'(busy), 32'd1);
    check("max_hdr_err",  32'(err),  32'd0);
    for (int j = 0; j < 1024; j++) send(8'(j), 0);
    if (CHK_EN) send(8'h00, 0);
    repeat (3) @(negedge clk);
    check("max_done",  32'(done), 32'd1);
    check("max_words", 32'(words_loaded), 32'd256);
    check("max_nwr",   32'(wr_data.size()), 32'd256);
    mism = 0;
    for (int k = 0; k < wr_data.size(); k++) begin
      if (wr_addr[k] != k ||
          wr_data[k] != {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)})
        mism++;
    end
    check("max_word_mismatches", 32'(mism), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    clear_log();
    do_start();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    check("chk_wait_cpu_rst", 32'(cpu_rst), 32'd1);
    check("chk_wait_done",    32'(done),    32'd0);
    send(8'hF6, 0);
    check("chk_good_done",    32'(done),    32'd1);
    check("chk_good_cpu_rst", 32'(cpu_rst), 32'd0);
    check("chk_good_data",    (wr_data.size() > 0) ? wr_data[0] : 32'hX, 32'h04030201);
    clear_log();
    do_start();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'hF7, 0);
    check("chk_bad_err",     32'(err),     32'd1);
    check("chk_bad_done",    32'(done),    32'd0);
    check("chk_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("chk_bad_nwr",     32'(wr_data.size()), 32'd1);
`endif

    check("ready_outside_load", 32'(ready_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
